// File: rtl/if_stage_mo.sv
// -----------------------------------------------------------------------------
// if_stage_mo : instruction fetch stage with multiple outstanding requests
//
// Issues in-order fetch requests on an SRAM-like bus (separate address and data
// handshakes). Up to MAX_OUTSTANDING requests may be accepted but not yet
// returned. Returned instructions are tagged with their PC and queued in an
// instruction buffer of IBUF_DEPTH entries that feeds decode.
//
// Handshakes:
//   fetch bus : a request is accepted on a rising edge with inst_sram_req &&
//               inst_sram_addr_ok; once raised, req/addr hold until accepted
//               (a flush may drop them). inst_sram_data_ok returns data in
//               request order, one word per edge.
//   decode    : the head entry moves to decode on a rising edge where
//               fs_to_ds_valid && ds_allowin; fs_to_ds_valid never depends on
//               ds_allowin.
//
// A flush (exc_flush or redirect_valid) empties the buffer and PC tag FIFO and
// marks every still-outstanding request (including one accepted in the flush
// cycle) for discard; their data_ok beats are swallowed.
//
// Optional feature: define IF_ADDR_CHECK_EN to check fetch PC alignment. A
// misaligned PC issues no bus request; instead one entry {pc, 0, adel=1} is
// queued and fetch holds until the next flush.
//
// Ports:
//   clk, reset              clock (rising edge), synchronous active-high reset
//   ds_allowin              decode accepts the head entry this cycle
//   fs_to_ds_valid/pc/inst/adel  buffer head
//   redirect_valid/pc       branch/eret redirect pulse and target
//   exc_flush               writeback exception pulse (wins over redirect)
//   fetch_stall             inhibit new requests
//   inst_sram_*             instruction bus (read only: wr=0, size=2, wdata=0)
// -----------------------------------------------------------------------------
module if_stage_mo #(
   parameter int          MAX_OUTSTANDING = 2,
   parameter int          IBUF_DEPTH      = 4,
   parameter logic [31:0] RESET_PC        = 32'hbfc00000,
   parameter logic [31:0] EXC_ENTRY       = 32'hbfc00380
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ds_allowin,
   output logic        fs_to_ds_valid,
   output logic [31:0] fs_to_ds_pc,
   output logic [31:0] fs_to_ds_inst,
   output logic        fs_to_ds_adel,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        exc_flush,
   input  logic        fetch_stall,
   output logic        inst_sram_req,
   output logic        inst_sram_wr,
   output logic [1:0]  inst_sram_size,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata,
   input  logic [31:0] inst_sram_rdata,
   input  logic        inst_sram_addr_ok,
   input  logic        inst_sram_data_ok
);

   localparam int AW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
   localparam int CW = $clog2(IBUF_DEPTH + 1);
   localparam int SW = ((CW > 3) ? CW : 3) + 1;
   localparam logic [2:0]    OSD_MAX = 3'(MAX_OUTSTANDING);
   localparam logic [SW-1:0] DEPTH_S = SW'(IBUF_DEPTH);
   localparam logic [AW-1:0] LAST_IX = AW'(IBUF_DEPTH - 1);

   // fetch PC and counters
   logic [31:0]   fpc;
   logic [2:0]    osd;
   logic [2:0]    discard;
   logic [CW-1:0] cnt;
   logic          req_hold;

   // PC tag FIFO; four slots cover the largest MAX_OUTSTANDING
   logic [31:0]   tag_pc [4];
   logic [1:0]    tag_wp;
   logic [1:0]    tag_rp;

   // instruction buffer
   logic [31:0]   ibuf_pc   [IBUF_DEPTH];
   logic [31:0]   ibuf_inst [IBUF_DEPTH];
   logic [AW-1:0] ib_wp;
   logic [AW-1:0] ib_rp;

   logic          flush;
   logic          can_issue;
   logic          hs;
   logic          dok;
   logic          dok_keep;
   logic          push;
   logic          pop;
   logic          misaligned;
   logic          adel_push;
   logic [2:0]    osd_next;
   logic [SW-1:0] occ;
   logic [31:0]   wr_pc;
   logic [31:0]   wr_inst;

   assign flush = exc_flush || redirect_valid;
   assign occ   = SW'(cnt) + SW'(osd);

`ifdef IF_ADDR_CHECK_EN
   logic          adel_done;
   logic          ibuf_adel [IBUF_DEPTH];

   assign misaligned = (fpc[1:0] != 2'b00);
   // Waits for osd == 0 so the error entry lands behind every older fetch.
   assign adel_push  = misaligned && !adel_done && (osd == 3'd0) &&
                       (occ < DEPTH_S) && !flush;
   assign fs_to_ds_adel = fs_to_ds_valid && ibuf_adel[ib_rp];
`else
   assign misaligned    = 1'b0;
   assign adel_push     = 1'b0;
   assign fs_to_ds_adel = 1'b0;
`endif

   assign can_issue = !fetch_stall && !misaligned && (osd < OSD_MAX) &&
                      (occ < DEPTH_S);
   // req_hold keeps a raised request up until addr_ok even if fetch_stall
   // rises meanwhile.
   assign inst_sram_req   = !reset && (req_hold || can_issue);
   assign inst_sram_addr  = fpc;
   assign inst_sram_wr    = 1'b0;
   assign inst_sram_size  = 2'd2;
   assign inst_sram_wdata = 32'd0;

   assign hs       = inst_sram_req && inst_sram_addr_ok;
   // A data_ok with nothing outstanding is stale and ignored.
   assign dok      = inst_sram_data_ok && (osd != 3'd0);
   assign dok_keep = dok && (discard == 3'd0);
   assign push     = (dok_keep || adel_push) && !flush;
   assign pop      = fs_to_ds_valid && ds_allowin && !flush;
   assign osd_next = osd + {2'b00, hs} - {2'b00, dok};

   assign wr_pc   = adel_push ? fpc : tag_pc[tag_rp];
   assign wr_inst = adel_push ? 32'd0 : inst_sram_rdata;

   assign fs_to_ds_valid = (cnt != '0);
   assign fs_to_ds_pc    = ibuf_pc[ib_rp];
   assign fs_to_ds_inst  = ibuf_inst[ib_rp];

   // fetch side: PC, outstanding/discard counts, tag FIFO
   always_ff @(posedge clk) begin
      if (reset) begin
         fpc      <= RESET_PC;
         osd      <= 3'd0;
         discard  <= 3'd0;
         req_hold <= 1'b0;
         tag_wp   <= 2'd0;
         tag_rp   <= 2'd0;
      end else begin
         osd      <= osd_next;
         req_hold <= inst_sram_req && !inst_sram_addr_ok && !flush;
         if (flush) begin
            fpc     <= exc_flush ? EXC_ENTRY : redirect_pc;
            // everything still in flight after this edge is stale
            discard <= osd_next;
            tag_wp  <= 2'd0;
            tag_rp  <= 2'd0;
         end else begin
            if (hs) begin
               fpc            <= fpc + 32'd4;
               tag_pc[tag_wp] <= fpc;
               tag_wp         <= tag_wp + 2'd1;
            end
            if (dok && (discard != 3'd0))
               discard <= discard - 3'd1;
            if (dok_keep)
               tag_rp <= tag_rp + 2'd1;
         end
      end
   end

   // instruction buffer
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= '0;
         ib_wp <= '0;
         ib_rp <= '0;
      end else if (flush) begin
         cnt   <= '0;
         ib_wp <= '0;
         ib_rp <= '0;
      end else begin
         cnt <= cnt + CW'(push) - CW'(pop);
         if (push) begin
            ibuf_pc[ib_wp]   <= wr_pc;
            ibuf_inst[ib_wp] <= wr_inst;
            ib_wp            <= (ib_wp == LAST_IX) ? '0 : ib_wp + AW'(1);
         end
         if (pop)
            ib_rp <= (ib_rp == LAST_IX) ? '0 : ib_rp + AW'(1);
      end
   end

`ifdef IF_ADDR_CHECK_EN
   always_ff @(posedge clk) begin
      if (reset || flush)
         adel_done <= 1'b0;
      else if (adel_push)
         adel_done <= 1'b1;
      if (!reset && push)
         ibuf_adel[ib_wp] <= adel_push;
   end
`endif

endmodule

// File: tb/tb_if_stage_mo.sv
// -----------------------------------------------------------------------------
// tb_if_stage_mo : self-checking bench for if_stage_mo
//
// An SRAM model answers fetches (instruction word is a fixed function of the
// address). Tests push expected decode entries {adel, pc, inst} into exp_q;
// each entry decode takes is popped and compared.
// -----------------------------------------------------------------------------
module tb_if_stage_mo;

   localparam logic [31:0] RESET_PC  = 32'hbfc00000;
   localparam logic [31:0] EXC_ENTRY = 32'hbfc00380;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ds_allowin = 1'b0;
   logic        fs_to_ds_valid;
   logic [31:0] fs_to_ds_pc;
   logic [31:0] fs_to_ds_inst;
   logic        fs_to_ds_adel;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        exc_flush = 1'b0;
   logic        fetch_stall = 1'b0;
   logic        inst_sram_req;
   logic        inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_rdata = 32'd0;
   logic        inst_sram_addr_ok = 1'b0;
   logic        inst_sram_data_ok = 1'b0;

   if_stage_mo #(
      .MAX_OUTSTANDING(2), .IBUF_DEPTH(4), .RESET_PC(RESET_PC), .EXC_ENTRY(EXC_ENTRY)
   ) dut (
      .clk(clk), .reset(reset), .ds_allowin(ds_allowin),
      .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_pc(fs_to_ds_pc),
      .fs_to_ds_inst(fs_to_ds_inst), .fs_to_ds_adel(fs_to_ds_adel),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .exc_flush(exc_flush), .fetch_stall(fetch_stall),
      .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
      .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
      .inst_sram_wdata(inst_sram_wdata), .inst_sram_rdata(inst_sram_rdata),
      .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok)
   );

   // clock / reset
   always #5 clk = ~clk;

   // scoreboard state
   logic [64:0] exp_q [$];
   logic [31:0] pend_q [$];
   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int rel_cyc  = 0;
   int first_del_cyc = 0;
   int last_del_cyc  = 0;
   bit got_first = 1'b0;
   int aok_mode = 1;   // 0 never, 1 always, 2 random
   int dok_mode = 1;   // 0 never, 1 always when pending, 2 random
   bit rst_dok  = 1'b0;
   bit          prev_req = 1'b0;
   bit          prev_aok = 1'b0;
   bit          prev_flush = 1'b0;
   logic [31:0] prev_addr = 32'd0;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1234_5678;
   endfunction

   function automatic logic [64:0] mk(input logic [31:0] pc);
      return {1'b0, pc, inst_of(pc)};
   endfunction

   task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
   endtask

   // SRAM model + decode-side comparison. Drives at negedge+1, samples at +2.
   initial begin
      logic [64:0] e;
      forever begin
         @(negedge clk);
         #1;
         cyc++;
         inst_sram_addr_ok = (aok_mode == 1) || (aok_mode == 2 && $urandom_range(0, 1) == 1);
         if (reset) begin
            inst_sram_data_ok = rst_dok;
            inst_sram_rdata   = 32'hdead_beef;
         end else if (pend_q.size() > 0 &&
                      (dok_mode == 1 || (dok_mode == 2 && $urandom_range(0, 2) != 0))) begin
            inst_sram_data_ok = 1'b1;
            inst_sram_rdata   = inst_of(pend_q[0]);
         end else begin
            inst_sram_data_ok = 1'b0;
            inst_sram_rdata   = $urandom;
         end
         #1;
         if (reset) begin
            pend_q.delete();
            prev_req = 1'b0;
         end else begin
            if (prev_req && !prev_aok && !prev_flush)
               check("req_hold", {inst_sram_req, inst_sram_addr}, {1'b1, prev_addr});
            if (fs_to_ds_valid && ds_allowin && !redirect_valid && !exc_flush &&
                exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("deliver", {fs_to_ds_adel, fs_to_ds_pc, fs_to_ds_inst}, e);
               if (!got_first) begin
                  first_del_cyc = cyc;
                  got_first = 1'b1;
               end
               last_del_cyc = cyc;
            end
            if (inst_sram_data_ok && pend_q.size() > 0) void'(pend_q.pop_front());
            if (inst_sram_req && inst_sram_addr_ok) pend_q.push_back(inst_sram_addr);
            prev_req   = inst_sram_req;
            prev_aok   = inst_sram_addr_ok;
            prev_addr  = inst_sram_addr;
            prev_flush = redirect_valid || exc_flush;
         end
      end
   end

   // driver tasks
   task automatic do_reset(input bit with_dok);
      @(negedge clk);
      reset = 1'b1;
      rst_dok = with_dok;
      redirect_valid = 1'b0;
      exc_flush = 1'b0;
      repeat (2) @(negedge clk);
      #3;
      check("rst_valid", fs_to_ds_valid, 0);
      check("rst_req", inst_sram_req, 0);
      check("rst_addr", inst_sram_addr, RESET_PC);
      @(negedge clk);
      reset = 1'b0;
      rst_dok = 1'b0;
      rel_cyc = cyc + 1;
      got_first = 1'b0;
   endtask

   task automatic push_seq(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(mk(base + 32'(4 * i)));
   endtask

   task automatic wait_drain(input string tag, input int limit);
      int t = 0;
      while (exp_q.size() != 0 && t < limit) begin
         @(negedge clk);
         t++;
      end
      check(tag, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic pulse_flush(input bit exc, input bit redir, input logic [31:0] pc);
      @(negedge clk);
      exc_flush = exc;
      redirect_valid = redir;
      redirect_pc = pc;
      ds_allowin = 1'b1;
      @(negedge clk);
      exc_flush = 1'b0;
      redirect_valid = 1'b0;
   endtask

   initial begin
      int t;
      // constant bus fields
      #1;
      check("const_wr", inst_sram_wr, 0);
      check("const_size", inst_sram_size, 2);
      check("const_wdata", inst_sram_wdata, 0);

      // streaming: one entry per cycle, first valid two cycles after release
      aok_mode = 1; dok_mode = 1; ds_allowin = 1'b1;
      do_reset(1'b0);
      push_seq(RESET_PC, 8);
      wait_drain("stream_drain", 100);
      ds_allowin = 1'b0;
      check("first_latency", first_del_cyc - rel_cyc, 2);
      check("one_per_cycle", last_del_cyc - first_del_cyc, 7);

      // backpressure: buffer fills, fetch stops, then drains in order and resumes
      do_reset(1'b0);
      repeat (12) @(negedge clk);
      #3;
      check("full_req_low", inst_sram_req, 0);
      check("full_valid", fs_to_ds_valid, 1);
      check("full_head_pc", fs_to_ds_pc, RESET_PC);
      check("full_osd_zero", pend_q.size(), 0);
      push_seq(RESET_PC, 10);
      @(negedge clk);
      ds_allowin = 1'b1;
      wait_drain("bp_drain", 100);
      ds_allowin = 1'b0;

      // redirect with two requests outstanding: both returns discarded
      dok_mode = 0;
      do_reset(1'b0);
      t = 0;
      while (pend_q.size() < 2 && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("two_outstanding", pend_q.size(), 2);
      #3;
      check("osd_limit_req", inst_sram_req, 0);
      dok_mode = 1;
      push_seq(32'h80000100, 4);
      pulse_flush(1'b0, 1'b1, 32'h80000100);
      wait_drain("redirect_drain", 100);
      ds_allowin = 1'b0;

      // exc_flush + redirect together on a full buffer
      do_reset(1'b0);
      repeat (12) @(negedge clk);
      #3;
      check("pre_flush_valid", fs_to_ds_valid, 1);
      push_seq(EXC_ENTRY, 4);
      pulse_flush(1'b1, 1'b1, 32'h80000100);
      #3;
      check("post_flush_valid", fs_to_ds_valid, 0);
      check("exc_addr", inst_sram_addr, EXC_ENTRY);
      wait_drain("exc_drain", 100);
      ds_allowin = 1'b0;

      // reset mid-transaction with data_ok asserted during reset
      dok_mode = 0; ds_allowin = 1'b1;
      do_reset(1'b0);
      repeat (4) @(negedge clk);
      check("mid_outstanding", pend_q.size(), 2);
      do_reset(1'b1);
      dok_mode = 1;
      push_seq(RESET_PC, 4);
      wait_drain("mid_reset_drain", 100);

      // random handshakes, backpressure and stalls
      aok_mode = 2; dok_mode = 2;
      do_reset(1'b0);
      push_seq(RESET_PC, 20);
      t = 0;
      while (exp_q.size() != 0 && t < 2000) begin
         @(negedge clk);
         ds_allowin  = ($urandom_range(0, 2) != 0);
         fetch_stall = ($urandom_range(0, 3) == 0);
         t++;
      end
      fetch_stall = 1'b0;
      wait_drain("random_drain", 1);
      aok_mode = 1; dok_mode = 1;

`ifdef IF_ADDR_CHECK_EN
      // misaligned redirect: error entry, no bus request
      ds_allowin = 1'b1;
      do_reset(1'b0);
      repeat (4) @(negedge clk);
      exp_q.push_back({1'b1, 32'h80000102, 32'd0});
      pulse_flush(1'b0, 1'b1, 32'h80000102);
      wait_drain("adel_drain", 100);
      repeat (4) @(negedge clk);
      #3;
      check("adel_no_req", inst_sram_req, 0);
      check("adel_once", fs_to_ds_valid, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/if_stage_mo.md
IF_STAGE_MO -- requirements
Module: if_stage_mo

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2: max accepted-but-unreturned fetches (1..4).
REQ-002 SHALL have parameter IBUF_DEPTH, default 4: instruction buffer entries (power of 2, >= MAX_OUTSTANDING).
REQ-003 SHALL have parameter RESET_PC, default 32'hbfc00000: first fetch address.
REQ-004 SHALL have parameter EXC_ENTRY, default 32'hbfc00380: exception redirect address.
REQ-005 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ds_allowin  in  1  decode accepts an entry this cycle.
- fs_to_ds_valid  out  1  buffer head valid.
- fs_to_ds_pc  out  32  head PC.
- fs_to_ds_inst  out  32  head instruction.
- fs_to_ds_adel  out  1  head carries fetch address error.
- redirect_valid  in  1  branch/eret redirect pulse.
- redirect_pc  in  32  redirect target.
- exc_flush  in  1  writeback exception pulse.
- fetch_stall  in  1  inhibit new requests (data-side bus busy).
- inst_sram_req  out  1;  inst_sram_wr  out  1 (const 0);  inst_sram_size  out  2 (const 2);  inst_sram_addr  out  32;  inst_sram_wdata  out  32 (const 0).
- inst_sram_rdata  in  32;  inst_sram_addr_ok  in  1;  inst_sram_data_ok  in  1.

Function
REQ-006 SHALL hold fetch PC register fpc; inst_sram_addr = fpc.
REQ-007 SHALL count outstanding (osd) and buffer occupancy (cnt); new request allowed only if !fetch_stall, osd < MAX_OUTSTANDING and osd + cnt < IBUF_DEPTH.
REQ-008 Once inst_sram_req rises, req and addr SHALL stay stable until addr_ok, except on a flush cycle.
REQ-009 Handshake (req && addr_ok) SHALL increment osd, push fpc into a PC tag FIFO, and set fpc to fpc+4 (32-bit wrap).
REQ-010 Data returns in order; data_ok with discard==0 SHALL decrement osd and write {tag PC, rdata, adel=0} into the buffer the same edge.
REQ-011 fs_to_ds_valid SHALL equal cnt != 0; head pops when fs_to_ds_valid && ds_allowin; simultaneous push and pop keep cnt unchanged.
REQ-012 Minimum latency: data_ok at edge N -> fs_to_ds_valid high in cycle N+1.
REQ-013 Flush (exc_flush or redirect_valid) SHALL: clear buffer and tag FIFO, set discard = osd after this cycle's handshake/data_ok, set fpc = EXC_ENTRY if exc_flush else redirect_pc; exc_flush has priority.
REQ-014 A request accepted in the flush cycle SHALL count in discard; data_ok while discard>0 SHALL decrement discard and osd and write nothing.
REQ-015 New requests after flush SHALL be allowed while discard>0, subject to REQ-007.
REQ-016 Pop is suppressed on a flush cycle; fs_to_ds_valid is 0 the cycle after flush.

Reset
REQ-017 On reset: fpc=RESET_PC, osd=cnt=discard=0, inst_sram_req=0, fs_to_ds_valid=0, buffers empty; first request no earlier than the first cycle after reset deasserts.
REQ-018 Reset mid-transaction SHALL abandon all in-flight state; a data_ok arriving during reset is ignored.

Configuration
REQ-019 Macro IF_ADDR_CHECK_EN defined: if fpc[1:0]!=0, no SRAM request; when cnt+osd < IBUF_DEPTH, push {fpc, 32'b0, adel=1} directly and hold fpc until flush.
REQ-020 IF_ADDR_CHECK_EN undefined: no alignment check, fs_to_ds_adel constant 0, fpc issued as-is.

Verification
REQ-021 Reset, addr_ok and data_ok always 1, ds_allowin=1 -> PCs bfc00000, bfc00004, bfc00008... delivered, one per cycle.
REQ-022 ds_allowin=0, single-cycle responses -> cnt reaches IBUF_DEPTH=4, osd=0, req low; ds_allowin=1 -> drains in order, fetching resumes.
REQ-023 Two requests outstanding, redirect_valid with redirect_pc=80000100 -> both returns discarded, next delivered PC 80000100.
REQ-024 exc_flush and redirect_valid same cycle -> next fetch at bfc00380.
REQ-025 IF_ADDR_CHECK_EN defined, redirect_pc=80000102 -> no req, entry pc=80000102 adel=1 inst=0 delivered.
